multi_note_writer: RTL and testbench
====================================

Name: multi_note_writer

Overview:
- Polyphonic, parametrised successor to the single-key note writer.
- Watches NUM_KEYS piano-key switches and times each held key in beats.
- On release (hold mode) or on press (tap mode), builds one record per key: {note, start address, duration}.
- Records share one RAM write port through a round-robin arbiter with a ready handshake. Sits between the key debouncers and the song RAM.

Parameters:
NUM_KEYS, 8, number of key switch inputs / channels (1..32)
NOTE_W, 6, note code width
ADDR_W, 7, width of cur_ram timestamp/address
DUR_W, 10, duration counter width (saturating)
NOTE_BASE, 6'd24, note code of key 0; key i has note NOTE_BASE+i (mod 2^NOTE_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
beat  in  1  beat strobe, sampled on clk; one count per clk edge where beat=1
cur_ram  in  ADDR_W  current RAM slot / song position
switch  in  NUM_KEYS  debounced key levels
is_hold_writer  in  1  1=hold mode (record on release), 0=tap mode (record on press, duration 0)
wr_ready  in  1  RAM port accepts payload this cycle
payload  out  NOTE_W+ADDR_W+DUR_W  {note, start_addr, duration}, MSB first
write_enable  out  1  payload valid
switch_high_pulse  out  NUM_KEYS  one-cycle rise pulse per key
switch_low_pulse  out  NUM_KEYS  one-cycle fall pulse per key
drop_count  out  8  saturating count of overwritten unsent records

Behaviour:
- Reset (sync, active-high): all outputs 0; sw_q, holding, pending, dur, start, rr_ptr, drop_count cleared. Reset mid-hold discards in-flight durations and pending records; no write is emitted for them.
- Edge detect: sw_q[i] registers switch[i].
  - rise = switch & ~sw_q; fall = ~switch & sw_q.
  - switch_high_pulse[i] / switch_low_pulse[i] are registered: high for exactly one cycle, the cycle after the edge is sampled.
- Per-key channel FSM, states IDLE / HOLD:
  - IDLE→HOLD on rise: start[i]<=cur_ram, dur[i]<=0. A beat in the rise cycle is not counted.
  - HOLD: dur[i]<=dur[i]+1 on each clk with beat=1; saturates at 2^DUR_W-1, no wrap.
  - HOLD→IDLE on fall: in hold mode, record {note_i, start[i], dur[i]} is loaded into pend_rec[i] and pend[i] set. A beat in the fall cycle is not counted.
  - Tap mode: record {note_i, cur_ram, 0} is loaded on rise instead; fall only returns the channel to IDLE.
  - is_hold_writer is sampled at the edge that produces the record.
- Pending slot: one record per key.
  - If a new record arrives while pend[i]=1 and that slot is not being consumed this cycle, the old record is overwritten and drop_count increments (saturates at 255).
  - If the slot is consumed in the same cycle, the new record stays pending and no drop is counted.
- Arbiter / output register:
  - Output may load when write_enable=0 or wr_ready=1.
  - Loads the first pending key at index ≥ rr_ptr (wrapping), clears that pend bit, and sets rr_ptr to idx+1 mod NUM_KEYS.
  - If nothing is pending and wr_ready=1, write_enable drops to 0.
  - payload and write_enable are held stable while write_enable=1 and wr_ready=0.
  - Latency: fall sampled at edge k → pend set at k → write_enable high after edge k+1 (port idle).
  - Throughput: one record per cycle.
- Simultaneous rises/falls on many keys are all captured; each is written exactly once unless overwritten (counted in drop_count).

Test Plan:
- Reset with switch=8'h00, cur_ram=25 for 2 cycles → all outputs 0; no write_enable for 10 idle cycles.
- Hold mode, wr_ready=1, NOTE_BASE=24:
  - Stimulus: key 2 rises with cur_ram=0x7F, then cur_ram=0; hold for exactly 10 beat cycles, then release.
  - Required: switch_high_pulse[2] for one cycle; then one write with payload={6'd26, 7'h7F, 10'd10}; switch_low_pulse[2] for one cycle.
- Tap mode: key 0 pressed at cur_ram=5 → write {24, 5, 0} two cycles after the press edge; release produces no write.
- Keys 1, 3, 6 released in the same cycle, wr_ready=1, rr_ptr=0 → three consecutive writes in order 1, 3, 6.
  - Then key 0 and key 6 pending together with rr_ptr=7 → key 0 written first.
- wr_ready=0 for 5 cycles with a record pending → payload stable, write_enable held.
  - Key 4 pressed and released twice during the stall → drop_count=1; only the second record is written after wr_ready=1.
- Key held for 1100 beats → duration 1023 (saturated); reset asserted mid-hold → no write, and drop_count remains 0.

Source files
------------

// File: rtl/multi_note_writer_if.sv
// Song-RAM write port: one record per cycle, held stable until wr_ready accepts it.
interface multi_note_writer_if #(
    parameter int PAY_W = 23
);
    logic [PAY_W-1:0] payload;
    logic             write_enable;
    logic             wr_ready;

    modport master (output payload, output write_enable, input wr_ready);
    modport slave  (input payload, input write_enable, output wr_ready);
endinterface

// File: rtl/multi_note_writer.sv
// Polyphonic note writer: times each held key in beats and sends {note, start, duration}
// records to the song RAM through a round-robin arbiter.
module multi_note_writer #(
    parameter int                NUM_KEYS  = 8,
    parameter int                NOTE_W    = 6,
    parameter int                ADDR_W    = 7,
    parameter int                DUR_W     = 10,
    parameter logic [NOTE_W-1:0] NOTE_BASE = 6'd24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat,
    input  logic [ADDR_W-1:0]    cur_ram,
    input  logic [NUM_KEYS-1:0]  switch,
    input  logic                 is_hold_writer,
    multi_note_writer_if.master  wr,
    output logic [NUM_KEYS-1:0]  switch_high_pulse,
    output logic [NUM_KEYS-1:0]  switch_low_pulse,
    output logic [7:0]           drop_count
);
    localparam int PAY_W = NOTE_W + ADDR_W + DUR_W;
    localparam int PTR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} chan_state_t;

    logic [NUM_KEYS-1:0] r_sw_q;
    logic [NUM_KEYS-1:0] r_high_pulse;
    logic [NUM_KEYS-1:0] r_low_pulse;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_fall;
    logic [NUM_KEYS-1:0] w_pend;
    logic [NUM_KEYS-1:0] w_drop;
    logic [NUM_KEYS-1:0] w_grant;
    logic [PAY_W-1:0]    w_pend_rec [NUM_KEYS];

    logic [PAY_W-1:0]    r_payload;
    logic                r_we;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [7:0]          r_drop_count;
    logic [7:0]          w_drop_count_next;
    logic                w_load_ok;
    logic                w_found;
    logic [PTR_W-1:0]    w_idx;

    assign w_rise = switch & ~r_sw_q;
    assign w_fall = ~switch & r_sw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_q       <= '0;
            r_high_pulse <= '0;
            r_low_pulse  <= '0;
        end else begin
            r_sw_q       <= switch;
            r_high_pulse <= w_rise;
            r_low_pulse  <= w_fall;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            localparam logic [NOTE_W-1:0] KEY_NOTE = NOTE_BASE + NOTE_W'(gi);

            chan_state_t       r_state, w_state_next;
            logic [DUR_W-1:0]  r_dur, w_dur_next;
            logic [ADDR_W-1:0] r_start, w_start_next;
            logic              w_nv;
            logic [PAY_W-1:0]  w_rec;
            logic              r_pend;
            logic [PAY_W-1:0]  r_pend_rec;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= IDLE;
                    r_dur   <= '0;
                    r_start <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_dur   <= w_dur_next;
                    r_start <= w_start_next;
                end
            end

            // Beats in the rise and fall cycles are deliberately not counted.
            always_comb begin
                w_state_next = r_state;
                w_dur_next   = r_dur;
                w_start_next = r_start;
                w_nv         = 1'b0;
                w_rec        = '0;
                case (r_state)
                    IDLE: begin
                        if (w_rise[gi]) begin
                            w_state_next = HOLD;
                            w_start_next = cur_ram;
                            w_dur_next   = '0;
                            if (!is_hold_writer) begin
                                w_nv  = 1'b1;
                                w_rec = {KEY_NOTE, cur_ram, {DUR_W{1'b0}}};
                            end
                        end
                    end
                    HOLD: begin
                        if (w_fall[gi]) begin
                            w_state_next = IDLE;
                            if (is_hold_writer) begin
                                w_nv  = 1'b1;
                                w_rec = {KEY_NOTE, r_start, r_dur};
                            end
                        end else if (beat && (r_dur != {DUR_W{1'b1}})) begin
                            w_dur_next = r_dur + 1'b1;
                        end
                    end
                    default: w_state_next = IDLE;
                endcase
            end

            // A new record wins over an unsent one; it only counts as a drop if the old one is not leaving now.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pend     <= 1'b0;
                    r_pend_rec <= '0;
                end else if (w_nv) begin
                    r_pend     <= 1'b1;
                    r_pend_rec <= w_rec;
                end else if (w_grant[gi]) begin
                    r_pend     <= 1'b0;
                end
            end

            assign w_pend[gi]     = r_pend;
            assign w_pend_rec[gi] = r_pend_rec;
            assign w_drop[gi]     = w_nv & r_pend & ~w_grant[gi];
        end
    endgenerate

    assign w_load_ok = ~r_we | wr.wr_ready;

    always_comb begin : p_arb
        int j;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_KEYS) j = j - NUM_KEYS;
            if (!w_found && w_pend[j]) begin
                w_found = 1'b1;
                w_idx   = PTR_W'(j);
            end
        end
        w_grant = (w_load_ok && w_found) ? (NUM_KEYS'(1) << w_idx) : '0;
    end

    always_comb begin : p_drop
        logic [5:0] drop_n;
        logic [8:0] drop_sum;
        drop_n = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            drop_n = drop_n + 6'(w_drop[k]);
        end
        drop_sum          = {1'b0, r_drop_count} + 9'(drop_n);
        w_drop_count_next = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_payload    <= '0;
            r_we         <= 1'b0;
            r_rr_ptr     <= '0;
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_count_next;
            if (w_load_ok) begin
                if (w_found) begin
                    r_payload <= w_pend_rec[w_idx];
                    r_we      <= 1'b1;
                    r_rr_ptr  <= (w_idx == PTR_W'(NUM_KEYS - 1)) ? '0 : w_idx + 1'b1;
                end else begin
                    r_we      <= 1'b0;
                end
            end
        end
    end

    assign wr.payload        = r_payload;
    assign wr.write_enable   = r_we;
    assign switch_high_pulse = r_high_pulse;
    assign switch_low_pulse  = r_low_pulse;
    assign drop_count        = r_drop_count;
endmodule

// File: tb/tb_multi_note_writer.sv
// Directed bench for multi_note_writer with the default 8-key, 23-bit payload configuration.
module tb_multi_note_writer;
    logic       clk = 1'b0;
    logic       reset;
    logic       beat;
    logic [6:0] cur_ram;
    logic [7:0] switch;
    logic       is_hold_writer;
    logic [7:0] switch_high_pulse;
    logic [7:0] switch_low_pulse;
    logic [7:0] drop_count;
    int         checks = 0;
    int         errors = 0;

    multi_note_writer_if #(.PAY_W(23)) wr_if ();

    multi_note_writer dut (
        .clk               (clk),
        .reset             (reset),
        .beat              (beat),
        .cur_ram           (cur_ram),
        .switch            (switch),
        .is_hold_writer    (is_hold_writer),
        .wr                (wr_if),
        .switch_high_pulse (switch_high_pulse),
        .switch_low_pulse  (switch_low_pulse),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] rec(input int n, input int a, input int d);
        return {6'(n), 7'(a), 10'(d)};
    endfunction

    initial begin
        logic [7:0]  sw_tab [5];
        logic [6:0]  ram_tab [5];
        int          we_seen;

        sw_tab  = '{8'h10, 8'h00, 8'h10, 8'h00, 8'h00};
        ram_tab = '{7'd40, 7'd40, 7'd41, 7'd41, 7'd41};

        // Reset and idle
        reset = 1'b1; beat = 1'b0; cur_ram = 7'd25; switch = 8'h00;
        is_hold_writer = 1'b1; wr_if.wr_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_we", 32'(wr_if.write_enable), 32'd0);
        chk("rst_payload", 32'(wr_if.payload), 32'd0);
        chk("rst_hi", 32'(switch_high_pulse), 32'd0);
        chk("rst_lo", 32'(switch_low_pulse), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_if.write_enable) we_seen++;
        end
        chk("idle_no_we", 32'(we_seen), 32'd0);

        // Hold mode, key 2, 10 beats
        cur_ram = 7'h7F; switch = 8'h04;
        tick();
        chk("hold_hi_pulse", 32'(switch_high_pulse), 32'h04);
        cur_ram = 7'd0;
        tick();
        chk("hold_hi_pulse_end", 32'(switch_high_pulse), 32'h00);
        beat = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        beat = 1'b0; switch = 8'h00;
        tick();
        chk("hold_lo_pulse", 32'(switch_low_pulse), 32'h04);
        chk("hold_we_latency", 32'(wr_if.write_enable), 32'd0);
        tick();
        chk("hold_we", 32'(wr_if.write_enable), 32'd1);
        chk("hold_payload", 32'(wr_if.payload), 32'(rec(26, 8'h7F, 10)));
        chk("hold_lo_pulse_end", 32'(switch_low_pulse), 32'h00);
        tick();
        chk("hold_single_write", 32'(wr_if.write_enable), 32'd0);

        // Tap mode, key 0
        is_hold_writer = 1'b0; cur_ram = 7'd5; switch = 8'h01;
        tick();
        chk("tap_we_latency", 32'(wr_if.write_enable), 32'd0);
        tick();
        chk("tap_we", 32'(wr_if.write_enable), 32'd1);
        chk("tap_payload", 32'(wr_if.payload), 32'(rec(24, 5, 0)));
        tick();
        chk("tap_single_write", 32'(wr_if.write_enable), 32'd0);
        switch = 8'h00;
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_if.write_enable) we_seen++;
        end
        chk("tap_release_no_write", 32'(we_seen), 32'd0);

        // Simultaneous release of keys 1, 3, 6 from rr_ptr=0
        reset = 1'b1; is_hold_writer = 1'b1;
        tick(); tick();
        reset = 1'b0; cur_ram = 7'd10; switch = 8'h4A;
        tick();
        chk("multi_hi_pulse", 32'(switch_high_pulse), 32'h4A);
        switch = 8'h00;
        tick();
        chk("multi_lo_pulse", 32'(switch_low_pulse), 32'h4A);
        tick();
        chk("multi_first_k1", 32'(wr_if.payload), 32'(rec(25, 10, 0)));
        tick();
        chk("multi_second_k3", 32'(wr_if.payload), 32'(rec(27, 10, 0)));
        chk("multi_second_we", 32'(wr_if.write_enable), 32'd1);
        tick();
        chk("multi_third_k6", 32'(wr_if.payload), 32'(rec(30, 10, 0)));
        tick();
        chk("multi_done", 32'(wr_if.write_enable), 32'd0);

        // Keys 0 and 6 pending with rr_ptr=7: key 0 wraps in first
        cur_ram = 7'd20; switch = 8'h41;
        tick();
        switch = 8'h00;
        tick();
        tick();
        chk("wrap_first_k0", 32'(wr_if.payload), 32'(rec(24, 20, 0)));
        tick();
        chk("wrap_second_k6", 32'(wr_if.payload), 32'(rec(30, 20, 0)));
        tick();
        chk("wrap_done", 32'(wr_if.write_enable), 32'd0);

        // Stall with key 5 in the output register; key 4 recorded twice meanwhile
        wr_if.wr_ready = 1'b0; cur_ram = 7'd40; switch = 8'h20;
        tick();
        switch = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            switch = sw_tab[i]; cur_ram = ram_tab[i];
            tick();
            chk($sformatf("stall_we_%0d", i), 32'(wr_if.write_enable), 32'd1);
            chk($sformatf("stall_payload_%0d", i), 32'(wr_if.payload), 32'(rec(29, 40, 0)));
        end
        chk("stall_drop", 32'(drop_count), 32'd1);
        wr_if.wr_ready = 1'b1;
        tick();
        chk("stall_second_rec", 32'(wr_if.payload), 32'(rec(28, 41, 0)));
        chk("stall_second_we", 32'(wr_if.write_enable), 32'd1);
        tick();
        chk("stall_done", 32'(wr_if.write_enable), 32'd0);

        // Saturating duration on key 7
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_drop_clear", 32'(drop_count), 32'd0);
        cur_ram = 7'd50; switch = 8'h80;
        tick();
        beat = 1'b1;
        for (int i = 0; i < 1100; i++) tick();
        beat = 1'b0; switch = 8'h00;
        tick();
        tick();
        chk("sat_we", 32'(wr_if.write_enable), 32'd1);
        chk("sat_payload", 32'(wr_if.payload), 32'(rec(31, 50, 1023)));
        tick();

        // Reset in the middle of a hold discards the record
        cur_ram = 7'd60; switch = 8'h08;
        tick();
        beat = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1; beat = 1'b0; switch = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk("midrst_hi", 32'(switch_high_pulse), 32'd0);
        chk("midrst_lo", 32'(switch_low_pulse), 32'd0);
        we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_if.write_enable) we_seen++;
        end
        chk("midrst_no_write", 32'(we_seen), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
